// File: rtl/up_down_count_monitor.sv
// Receiving-side checker for a wrapping LO..HI up/down counter: infers direction, flags illegal
// steps and tallies wraps. Wrap tallies are built only when UP_DOWN_COUNT_MON_WRAP_CNT_EN is defined.
module up_down_count_monitor #(
    parameter int unsigned LO     = 3,
    parameter int unsigned HI     = 15,
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [3:0]        count_in,
    input  logic              clr_err,
    output logic              dir,
    output logic              dir_valid,
    output logic              step_err,
    output logic              err_sticky,
    output logic [WRAP_W-1:0] wrap_up_cnt,
    output logic [WRAP_W-1:0] wrap_dn_cnt
);

    typedef enum logic [1:0] {StIdle, StTrack, StFault} state_e;

    localparam logic [4:0] LoW = 5'(LO);
    localparam logic [4:0] HiW = 5'(HI);

    state_e     state_q, state_d;
    logic [3:0] prev_q, prev_d;
    logic       dir_q, dir_d;
    logic       dir_valid_q, dir_valid_d;
    logic       step_err_q, step_err_d;
    logic       err_sticky_q, err_sticky_d;

    logic [4:0] cnt5, prev5;
    logic       in_range, is_hold, is_up, is_dn, track_step;

    // 5-bit arithmetic keeps prev+1 / prev-1 from aliasing across 0/15.
    assign cnt5       = {1'b0, count_in};
    assign prev5      = {1'b0, prev_q};
    assign in_range   = (cnt5 >= LoW) && (cnt5 <= HiW);
    assign is_hold    = (cnt5 == prev5);
    assign is_up      = ((prev5 != HiW) && (cnt5 == prev5 + 5'd1)) ||
                        ((prev5 == HiW) && (cnt5 == LoW));
    assign is_dn      = ((prev5 != LoW) && (cnt5 == prev5 - 5'd1)) ||
                        ((prev5 == LoW) && (cnt5 == HiW));
    assign track_step = !clr_err && sample_valid && (state_q == StTrack);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        dir_d        = dir_q;
        dir_valid_d  = dir_valid_q;
        step_err_d   = 1'b0;
        err_sticky_d = err_sticky_q;

        if (clr_err) begin
            state_d      = StIdle;
            err_sticky_d = 1'b0;
            dir_valid_d  = 1'b0;
        end else if (sample_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (in_range) begin
                        prev_d  = count_in;
                        state_d = StTrack;
                    end else begin
                        step_err_d   = 1'b1;
                        err_sticky_d = 1'b1;
                        state_d      = StFault;
                    end
                end
                StTrack: begin
                    if (is_hold) begin
                        prev_d = count_in;
                    end else if (is_up) begin
                        prev_d      = count_in;
                        dir_d       = 1'b1;
                        dir_valid_d = 1'b1;
                    end else if (is_dn) begin
                        prev_d      = count_in;
                        dir_d       = 1'b0;
                        dir_valid_d = 1'b1;
                    end else begin
                        step_err_d   = 1'b1;
                        err_sticky_d = 1'b1;
                        state_d      = StFault;
                    end
                end
                StFault: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            prev_q       <= LoW[3:0];
            dir_q        <= 1'b0;
            dir_valid_q  <= 1'b0;
            step_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            dir_q        <= dir_d;
            dir_valid_q  <= dir_valid_d;
            step_err_q   <= step_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign dir        = dir_q;
    assign dir_valid  = dir_valid_q;
    assign step_err   = step_err_q;
    assign err_sticky = err_sticky_q;

`ifdef UP_DOWN_COUNT_MON_WRAP_CNT_EN
    logic              wrap_up_evt, wrap_dn_evt;
    logic [WRAP_W-1:0] wrap_up_q, wrap_up_d, wrap_dn_q, wrap_dn_d;

    // Hold is excluded by construction: a wrap step always changes the value.
    assign wrap_up_evt = track_step && is_up && (prev5 == HiW);
    assign wrap_dn_evt = track_step && !is_up && is_dn && (prev5 == LoW);

    always_comb begin
        wrap_up_d = wrap_up_q;
        wrap_dn_d = wrap_dn_q;
        if (wrap_up_evt && (wrap_up_q != '1)) wrap_up_d = wrap_up_q + 1'b1;
        if (wrap_dn_evt && (wrap_dn_q != '1)) wrap_dn_d = wrap_dn_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_up_q <= '0;
            wrap_dn_q <= '0;
        end else begin
            wrap_up_q <= wrap_up_d;
            wrap_dn_q <= wrap_dn_d;
        end
    end

    assign wrap_up_cnt = wrap_up_q;
    assign wrap_dn_cnt = wrap_dn_q;
`else
    logic unused_track;
    assign unused_track = track_step;
    assign wrap_up_cnt  = '0;
    assign wrap_dn_cnt  = '0;
`endif

endmodule

// File: tb/tb_up_down_count_monitor.sv
// Randomized plus directed bench for up_down_count_monitor against a position-modulo-N model.
module tb_up_down_count_monitor;

    localparam int LO = 3;
    localparam int HI = 15;
    localparam int N  = HI - LO + 1;

`ifdef UP_DOWN_COUNT_MON_WRAP_CNT_EN
    localparam bit TallyEn = 1'b1;
`else
    localparam bit TallyEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       sample_valid = 1'b0;
    logic [3:0] count_in = 4'd0;
    logic       clr_err = 1'b0;
    logic       chk_en = 1'b0;

    logic       dir8, dv8, se8, es8;
    logic [7:0] wu8, wd8;
    logic       dir2, dv2, se2, es2;
    logic [1:0] wu2, wd2;

    int n_checks = 0;
    int n_err    = 0;

    up_down_count_monitor #(.LO(LO), .HI(HI), .WRAP_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .count_in(count_in),
        .clr_err(clr_err), .dir(dir8), .dir_valid(dv8), .step_err(se8), .err_sticky(es8),
        .wrap_up_cnt(wu8), .wrap_dn_cnt(wd8)
    );

    up_down_count_monitor #(.LO(LO), .HI(HI), .WRAP_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .count_in(count_in),
        .clr_err(clr_err), .dir(dir2), .dir_valid(dv2), .step_err(se2), .err_sticky(es2),
        .wrap_up_cnt(wu2), .wrap_dn_cnt(wd2)
    );

    always #5 clk = ~clk;

    // Model: st 0=idle 1=track 2=fault; tallies kept unbounded, saturated on compare.
    typedef struct packed {
        logic [1:0] st;
        logic [3:0] prev;
        logic       dir;
        logic       dv;
        logic       step;
        logic       sticky;
        int         wu;
        int         wd;
    } mdl_t;

    localparam mdl_t MdlReset = '{st: 2'd0, prev: 4'(LO), dir: 1'b0, dv: 1'b0, step: 1'b0,
                                  sticky: 1'b0, wu: 0, wd: 0};
    mdl_t m = MdlReset;

    function automatic mdl_t nxt(mdl_t s, logic v, logic [3:0] c, logic clr);
        mdl_t n = s;
        int p, q;
        bit bad;
        n.step = 1'b0;
        bad = 1'b0;
        p = int'(s.prev) - LO;
        q = int'(c) - LO;
        if (clr) begin
            n.st = 2'd0;
            n.sticky = 1'b0;
            n.dv = 1'b0;
        end else if (v && s.st == 2'd0) begin
            if (q >= 0 && q < N) begin
                n.st = 2'd1;
                n.prev = c;
            end else bad = 1'b1;
        end else if (v && s.st == 2'd1) begin
            if (q < 0 || q >= N) bad = 1'b1;
            else if (q == p) n.prev = c;
            else if (q == (p + 1) % N) begin
                n.prev = c; n.dir = 1'b1; n.dv = 1'b1;
                if (q == 0) n.wu = s.wu + 1;
            end else if (q == (p + N - 1) % N) begin
                n.prev = c; n.dir = 1'b0; n.dv = 1'b1;
                if (p == 0) n.wd = s.wd + 1;
            end else bad = 1'b1;
        end
        if (bad) begin
            n.st = 2'd2;
            n.step = 1'b1;
            n.sticky = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= MdlReset;
        else        m <= nxt(m, sample_valid, count_in, clr_err);
    end

    function automatic int sat(int x, int w);
        int mx = (1 << w) - 1;
        if (!TallyEn) return 0;
        return (x > mx) ? mx : x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dir8", 32'(dir8), 32'(m.dir));
            chk("dir_valid8", 32'(dv8), 32'(m.dv));
            chk("step_err8", 32'(se8), 32'(m.step));
            chk("err_sticky8", 32'(es8), 32'(m.sticky));
            chk("wrap_up8", 32'(wu8), 32'(sat(m.wu, 8)));
            chk("wrap_dn8", 32'(wd8), 32'(sat(m.wd, 8)));
            chk("dir2", 32'(dir2), 32'(m.dir));
            chk("step_err2", 32'(se2), 32'(m.step));
            chk("wrap_up2", 32'(wu2), 32'(sat(m.wu, 2)));
            chk("wrap_dn2", 32'(wd2), 32'(sat(m.wd, 2)));
        end
    end

    task automatic drv(input logic v, input int c, input logic clr);
        @(negedge clk);
        sample_valid = v;
        count_in = 4'(c);
        clr_err = clr;
    endtask

    task automatic idle();
        drv(1'b0, 0, 1'b0);
    endtask

    int val;

    initial begin
        #3 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_dir_valid", 32'(dv8), 32'd0);
        chk("rst_wrap_up", 32'(wu8), 32'd0);
        rst_n = 1'b1;

        // Up sequence
        drv(1'b1, 3, 1'b0);
        drv(1'b1, 4, 1'b0);
        drv(1'b1, 5, 1'b0);
        chk("t1_dir", 32'(dir8), 32'd1);
        chk("t1_dir_valid", 32'(dv8), 32'd1);
        for (int i = 6; i <= 15; i++) drv(1'b1, i, 1'b0);
        drv(1'b1, 3, 1'b0);
        drv(1'b1, 4, 1'b0);
        chk("t2_wrap_up", 32'(wu8), 32'(TallyEn ? 1 : 0));
        chk("t2_dir_up", 32'(dir8), 32'd1);
        drv(1'b1, 4, 1'b0);
        drv(1'b1, 3, 1'b0);
        drv(1'b1, 15, 1'b0);
        idle();
        chk("t2_dir_dn", 32'(dir8), 32'd0);
        chk("t2_wrap_dn", 32'(wd8), 32'(TallyEn ? 1 : 0));

        // Illegal jump
        for (int i = 14; i >= 7; i--) drv(1'b1, i, 1'b0);
        drv(1'b1, 9, 1'b0);
        drv(1'b1, 10, 1'b0);
        chk("t3_step_err", 32'(se8), 32'd1);
        chk("t3_sticky", 32'(es8), 32'd1);
        drv(1'b1, 11, 1'b0);
        chk("t3_step_pulse", 32'(se8), 32'd0);
        idle();
        chk("t3_sticky_hold", 32'(es8), 32'd1);

        // Clear colliding with a sample
        drv(1'b1, 5, 1'b1);
        idle();
        chk("t4_sticky_clr", 32'(es8), 32'd0);
        chk("t4_dv_clr", 32'(dv8), 32'd0);
        drv(1'b1, 5, 1'b0);
        drv(1'b1, 6, 1'b0);
        idle();
        chk("t4_dv_set", 32'(dv8), 32'd1);

        // Out of range in idle, then holds
        drv(1'b0, 0, 1'b1);
        drv(1'b1, 2, 1'b0);
        idle();
        chk("t5_oor_sticky", 32'(es8), 32'd1);
        drv(1'b0, 0, 1'b1);
        repeat (3) drv(1'b1, 8, 1'b0);
        idle();
        chk("t5_hold_err", 32'(es8), 32'd0);
        chk("t5_hold_dv", 32'(dv8), 32'd0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            int r, k;
            r = $urandom_range(0, 99);
            k = $urandom_range(0, 9);
            if (k <= 3)      val = (int'(m.prev) == HI) ? LO : int'(m.prev) + 1;
            else if (k <= 6) val = (int'(m.prev) == LO) ? HI : int'(m.prev) - 1;
            else if (k == 7) val = int'(m.prev);
            else             val = $urandom_range(0, 15);
            drv(r < 85, val, (m.st == 2'd2) ? (r < 20) : (r >= 98));
        end

        // Mid-cycle asynchronous reset
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_dir_valid", 32'(dv8), 32'd0);
        chk("async_sticky", 32'(es8), 32'd0);
        chk("async_wrap_up", 32'(wu8), 32'd0);
        chk("async_wrap_dn", 32'(wd8), 32'd0);
        chk("async_dir", 32'(dir8), 32'd0);
        idle();
        rst_n = 1'b1;

        // Saturation of the 2-bit tally
        drv(1'b1, 3, 1'b0);
        for (int w = 0; w < 4; w++) begin
            for (int i = 4; i <= 15; i++) drv(1'b1, i, 1'b0);
            drv(1'b1, 3, 1'b0);
        end
        idle();
        chk("sat_wrap_up2", 32'(wu2), 32'(TallyEn ? 3 : 0));
        chk("sat_wrap_up8", 32'(wu8), 32'(TallyEn ? 4 : 0));
        idle();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
